// File: rtl/pe_mac_seq_pkg.sv
// Shared types and default sizing for the PE multiply-accumulate sequencer.
package pe_mac_seq_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ACC_W_DEF   = 65;
  localparam int K_MAX_DEF   = 16;
  localparam int ADDR_W_DEF  = $clog2(K_MAX_DEF);
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_LOAD,
    ST_WAIT,
    ST_OUT,
    ST_ERR
  } state_t;

endpackage

// File: rtl/pe_mac_seq_step_ctr.sv
// Loadable MAC step counter; last flags the final step (step == len-1) and stops the count there.
module pe_mac_seq_step_ctr
  import pe_mac_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W:0]   len,
  input  logic              inc,
  output logic [ADDR_W-1:0] step,
  output logic              last
);

  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] STEP_ONE = ADDR_W'(1);

  logic [ADDR_W:0] len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step  <= '0;
      len_q <= '0;
    end else if (load) begin
      step  <= '0;
      len_q <= len;
    end else if (inc && !last) begin
      step <= step + STEP_ONE;
    end
  end

  // len_q of zero wraps to all-ones here, so last never fires for an empty job.
  assign last = ({1'b0, step} == (len_q - LEN_ONE));

endmodule

// File: rtl/pe_mac_sequencer.sv
// Runs one PE through a K-step MAC job: clear, fetch/load per step, wait for done, present result.
// Optional wait-timeout with ERR state is enabled by defining PE_MAC_SEQ_TIMEOUT_EN.
module pe_mac_sequencer
  import pe_mac_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int K_MAX  = K_MAX_DEF,
  parameter int ADDR_W = $clog2(K_MAX)
`ifdef PE_MAC_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   k_len,
  output logic              busy,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_rd_data,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic              pe_rst,
  output logic              pe_load,
  output logic [DATA_W-1:0] pe_row,
  output logic [DATA_W-1:0] pe_col,
  input  logic              pe_done,
  input  logic [ACC_W-1:0]  pe_result,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              err
);

  localparam logic [ADDR_W:0] K_MAX_L = (ADDR_W+1)'(K_MAX);

  function automatic logic [ADDR_W:0] sat_k_len(input logic [ADDR_W:0] k);
    return (k > K_MAX_L) ? K_MAX_L : k;
  endfunction

  state_t            state;
  state_t            state_next;
  logic              ctr_load;
  logic              ctr_inc;
  logic [ADDR_W-1:0] step;
  logic              last;

  pe_mac_seq_step_ctr #(
    .ADDR_W (ADDR_W)
  ) u_step_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (ctr_load),
    .len  (sat_k_len(k_len)),
    .inc  (ctr_inc),
    .step (step),
    .last (last)
  );

  // Both buffers are walked in lockstep, so the step register drives both addresses.
  assign a_addr = step;
  assign b_addr = step;

`ifdef PE_MAC_SEQ_TIMEOUT_EN
  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (rst || (state != ST_WAIT)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_ONE;
    end
  end

  assign timeout = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state_next == ST_ERR) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          ctr_load   = 1'b1;
          state_next = (k_len == '0) ? ST_OUT : ST_CLEAR;
        end
      end
      ST_CLEAR: state_next = ST_FETCH;
      ST_FETCH: state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (pe_done) begin
          if (last) begin
            state_next = ST_OUT;
          end else begin
            ctr_inc    = 1'b1;
            state_next = ST_FETCH;
          end
        end
`ifdef PE_MAC_SEQ_TIMEOUT_EN
        else if (timeout) begin
          state_next = ST_ERR;
        end
`endif
      end
      ST_OUT: begin
        if (result_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      a_rd_en      <= 1'b0;
      b_rd_en      <= 1'b0;
      pe_rst       <= 1'b1;
      pe_load      <= 1'b0;
      pe_row       <= '0;
      pe_col       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      busy         <= (state_next != ST_IDLE);
      a_rd_en      <= (state_next == ST_FETCH);
      b_rd_en      <= (state_next == ST_FETCH);
      pe_rst       <= (state_next == ST_CLEAR) || (state_next == ST_ERR);
      result_valid <= (state_next == ST_OUT);
      // Buffer data is valid during LOAD; the PE sees operands and load together one cycle later.
      pe_load      <= (state == ST_LOAD);
      if (state == ST_LOAD) begin
        pe_row <= a_rd_data;
        pe_col <= b_rd_data;
      end
      if ((state == ST_IDLE) && start && (k_len == '0)) begin
        result <= '0;
      end else if ((state == ST_WAIT) && pe_done && last) begin
        result <= pe_result;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Self-checking bench for pe_mac_sequencer: buffer and PE models, vector table, corner sequences, random jobs.
module tb_pe_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  k_len;
  logic        busy;
  logic        a_rd_en, b_rd_en;
  logic [3:0]  a_addr, b_addr;
  logic [31:0] a_rd_data, b_rd_data;
  logic        pe_rst, pe_load, pe_done;
  logic [31:0] pe_row, pe_col;
  logic [64:0] pe_result;
  logic [64:0] result;
  logic        result_valid, result_ready;
  logic        err;

  always #5 clk = ~clk;

  pe_mac_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .k_len        (k_len),
    .busy         (busy),
    .a_rd_en      (a_rd_en),
    .a_addr       (a_addr),
    .a_rd_data    (a_rd_data),
    .b_rd_en      (b_rd_en),
    .b_addr       (b_addr),
    .b_rd_data    (b_rd_data),
    .pe_rst       (pe_rst),
    .pe_load      (pe_load),
    .pe_row       (pe_row),
    .pe_col       (pe_col),
    .pe_done      (pe_done),
    .pe_result    (pe_result),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .err          (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operand buffers with one-cycle registered read
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_addr];
  end

  // PE model: multiply on load, accumulate, pulse done after pe_lat cycles
  int          pe_lat  = 4;
  bit          pe_hang = 1'b0;
  int          pe_cnt;
  bit          pe_pend;
  logic [64:0] pe_acc;
  logic [31:0] op_r, op_c;

  initial begin
    pe_done   = 1'b0;
    pe_result = '0;
    pe_acc    = '0;
    pe_pend   = 1'b0;
    pe_cnt    = 0;
  end

  always @(posedge clk) begin
    pe_done <= 1'b0;
    if (pe_rst) begin
      pe_acc  <= '0;
      pe_pend <= 1'b0;
    end else if (pe_load) begin
      pe_pend <= 1'b1;
      pe_cnt  <= pe_lat;
      op_r    <= pe_row;
      op_c    <= pe_col;
    end else if (pe_pend) begin
      if (pe_cnt <= 1) begin
        pe_pend   <= 1'b0;
        pe_done   <= !pe_hang;
        pe_acc    <= pe_acc + 65'(op_r) * 65'(op_c);
        pe_result <= pe_acc + 65'(op_r) * 65'(op_c);
      end else begin
        pe_cnt <= pe_cnt - 1;
      end
    end
  end

  // Observation of strobes, sampled mid-cycle
  int         n_load = 0;
  int         n_prst = 0;
  logic [3:0] a_log [$];
  logic [3:0] b_log [$];

  always @(negedge clk) begin
    if (pe_load) n_load++;
    if (pe_rst)  n_prst++;
    if (a_rd_en) a_log.push_back(a_addr);
    if (b_rd_en) b_log.push_back(b_addr);
  end

  // Reference: dot product of the first min(k,16) operand pairs, modulo 2^65
  function automatic logic [64:0] ref_mac(input int k);
    int n = (k > 16) ? 16 : k;
    logic [64:0] s = '0;
    for (int i = 0; i < n; i++) s += 65'(mem_a[i]) * 65'(mem_b[i]);
    return s;
  endfunction

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       begin mem_a[i] = 32'(i + 1); mem_b[i] = 32'(i + 4); end
        1:       begin mem_a[i] = 32'hFFFF_FFFF; mem_b[i] = 32'hFFFF_FFFF; end
        default: begin mem_a[i] = $urandom; mem_b[i] = $urandom; end
      endcase
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!result_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_job(input string tag, input int k, input logic [64:0] exp, input int rdy_dly);
    int n      = (k > 16) ? 16 : k;
    int base_l = n_load;
    int base_r = n_prst;
    int base_a = a_log.size();
    int base_b = b_log.size();
    int cyc;
    bit ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    k_len = 5'(k);
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    check({tag, " valid"}, result_valid, 1'b1);
    if (k == 0) check({tag, " k0 latency"}, (cyc <= 1), 1'b1);
    check({tag, " result"}, result, exp);
    check({tag, " loads"}, n_load - base_l, n);
    check({tag, " pe_rst"}, n_prst - base_r, (n > 0) ? 1 : 0);
    if ((a_log.size() - base_a != n) || (b_log.size() - base_b != n)) ok = 1'b0;
    else for (int i = 0; i < n; i++)
      if (a_log[base_a+i] != 4'(i) || b_log[base_b+i] != 4'(i)) ok = 1'b0;
    check({tag, " addr seq"}, ok, 1'b1);
    repeat (rdy_dly) @(negedge clk);
    check({tag, " held valid"}, result_valid, 1'b1);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, " valid drop"}, result_valid, 1'b0);
    check({tag, " idle"}, busy, 1'b0);
  endtask

  typedef struct {
    string       name;
    int          k;
    int          mode;
    logic [64:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cyc;
    int base_l;

    tbl[0] = '{"k3 small",  3,  0, 65'd32};
    tbl[1] = '{"k0 empty",  0,  0, 65'd0};
    tbl[2] = '{"k2 ones",   2,  1, 65'h1_FFFF_FFFC_0000_0002};
    tbl[3] = '{"k1 small",  1,  0, 65'd4};
    tbl[4] = '{"k20 sat",   20, 0, 65'd1904};
    tbl[5] = '{"k16 ones",  16, 1, 65'h1_FFFF_FFE0_0000_0010};

    rst          = 1'b1;
    start        = 1'b0;
    k_len        = '0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst pe_rst", pe_rst, 1'b1);
    check("rst valid", result_valid, 1'b0);
    check("rst result", result, '0);
    check("rst pe_load", pe_load, 1'b0);
    check("rst rd_en", {a_rd_en, b_rd_en}, 2'b00);
    check("rst err", err, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post-rst pe_rst", pe_rst, 1'b0);

    for (int t = 0; t < 6; t++) begin
      fill_mem(tbl[t].mode);
      pe_lat = 4;
      run_job(tbl[t].name, tbl[t].k, tbl[t].exp, 1);
    end

    // Stall in OUT: result stable, stray start ignored
    fill_mem(0);
    @(negedge clk);
    start = 1'b1;
    k_len = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      check("stall result", result, 65'd32);
      check("stall valid", result_valid, 1'b1);
      check("stall busy", busy, 1'b1);
      start = (i == 1);
      k_len = 5'd1;
      @(negedge clk);
    end
    start = 1'b0;
    check("stall result end", result, 65'd32);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("stall release valid", result_valid, 1'b0);
    check("stall release busy", busy, 1'b0);
    base_l = n_load;
    repeat (5) @(negedge clk);
    check("stray start busy", busy, 1'b0);
    check("stray start loads", n_load - base_l, 0);

    // Reset while waiting on the PE
    pe_lat = 30;
    base_l = n_load;
    @(negedge clk);
    start = 1'b1;
    k_len = 5'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (n_load == base_l && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("wait reached", (n_load > base_l), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("wrst busy", busy, 1'b0);
    check("wrst pe_rst", pe_rst, 1'b1);
    check("wrst pe_row/col", {pe_row, pe_col}, 64'd0);
    check("wrst pe_load", pe_load, 1'b0);
    check("wrst valid", result_valid, 1'b0);
    check("wrst result", result, '0);
    check("wrst addr", {a_addr, b_addr}, 8'd0);
    check("wrst rd_en", {a_rd_en, b_rd_en}, 2'b00);
    repeat (2) @(negedge clk);
    pe_lat = 2;
    run_job("after wrst", 3, 65'd32, 0);

    // Random jobs against the reference model
    for (int r = 0; r < 10; r++) begin
      fill_mem(2);
      pe_lat = $urandom_range(1, 6);
      begin
        int k = $urandom_range(0, 20);
        run_job($sformatf("rand%0d k%0d", r, k), k, ref_mac(k), $urandom_range(0, 3));
      end
    end

`ifdef PE_MAC_SEQ_TIMEOUT_EN
    // PE never answers: err after exactly 64 WAIT cycles
    pe_hang = 1'b1;
    pe_lat  = 1;
    base_l  = n_load;
    @(negedge clk);
    start = 1'b1;
    k_len = 5'd2;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (n_load == base_l && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (63) @(negedge clk);
    check("to err before", err, 1'b0);
    @(negedge clk);
    check("to err", err, 1'b1);
    check("to pe_rst", pe_rst, 1'b1);
    check("to busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    check("to err sticky", err, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("to err cleared", err, 1'b0);
    pe_hang = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/pe_mac_sequencer.md
Name: pe_mac_sequencer

Overview:
Controller that runs one processing element through a K-step multiply-accumulate job. It clears the PE accumulator, fetches operand pairs from two operand buffers (A-row, B-column), and issues one PE load per pair. It waits for the PE's done per step, then presents the final accumulated result on a valid/ready output. It sits between the matrix-multiplier top-level scheduler and each PE instance.

Parameters:
DATA_W, 32, operand width (PE row/col width)
ACC_W, 65, accumulator/result width (PE result width)
K_MAX, 16, maximum steps per job
ADDR_W, 4, operand buffer address width, equal to clog2(K_MAX)
TIMEOUT_CYCLES, 64, max cycles waiting for pe_done per step (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job request; sampled only in IDLE
k_len  in  ADDR_W+1  number of MAC steps; sampled with start
busy  out  1  high in every state except IDLE
a_rd_en  out  1  A buffer read strobe
a_addr  out  ADDR_W  A buffer address
a_rd_data  in  DATA_W  A data, valid 1 cycle after a_rd_en
b_rd_en  out  1  B buffer read strobe
b_addr  out  ADDR_W  B buffer address
b_rd_data  in  DATA_W  B data, valid 1 cycle after b_rd_en
pe_rst  out  1  PE synchronous clear
pe_load  out  1  one-cycle PE load strobe
pe_row  out  DATA_W  PE row operand
pe_col  out  DATA_W  PE column operand
pe_done  in  1  PE step-complete pulse; pe_result is valid in the same cycle
pe_result  in  ACC_W  PE accumulated value
result  out  ACC_W  job result
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
err  out  1  timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - busy=0, a_rd_en=0, b_rd_en=0, addresses=0, pe_load=0, pe_row=0, pe_col=0, result=0, result_valid=0, err=0.
  - pe_rst=1 during reset; state=IDLE.
- States: IDLE, CLEAR, FETCH, LOAD, WAIT, OUT, ERR (ERR only with the optional feature).
- IDLE:
  - start=1 with k_len=0 -> OUT directly with result=0. No pe_rst, no pe_load.
  - start=1 with k_len>K_MAX -> k_len is saturated to K_MAX.
  - Otherwise latch k_len and set step=0 -> CLEAR.
- CLEAR: pe_rst=1 for exactly 1 cycle -> FETCH.
- FETCH:
  - a_rd_en=b_rd_en=1 for 1 cycle.
  - a_addr=b_addr=step.
  - -> LOAD.
- LOAD:
  - Capture a_rd_data/b_rd_data onto pe_row/pe_col and assert pe_load=1 for 1 cycle.
  - pe_row/pe_col hold their values until the next LOAD.
  - -> WAIT.
- WAIT: hold until pe_done=1.
  - If step==k_len-1: result<=pe_result -> OUT.
  - Else: step<=step+1 -> FETCH.
  - pe_done seen in any other state is ignored.
- OUT: result_valid=1; result stays stable until result_ready=1. On handshake, result_valid<=0 -> IDLE.
- Per-step overhead is 3 cycles plus PE latency (FETCH, LOAD, the cycle pe_done is observed).
- start while busy is ignored; it is not queued.
- rst in any state returns to IDLE on the next edge, drops result_valid, and asserts pe_rst.
- step never wraps: the maximum index is K_MAX-1.

Optional Feature:
Macro PE_MAC_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and counts each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without pe_done: go to ERR, set err=1, assert pe_rst.
  - ERR is exited only by rst. busy stays 1 in ERR.
- Not defined: no counter and no ERR state; err is tied 0; WAIT is unbounded.

Decomposition:
- Package pe_mac_seq_pkg: state enum, DATA_W/ACC_W defaults, derived ADDR_W, TIMEOUT default.
- One sub-module, pe_mac_seq_step_ctr: loadable step counter with a last-step compare output (step==k_len-1).

Test Plan:
- k_len=3, A={1,2,3}, B={4,5,6}, PE model with 4-cycle latency -> exactly 3 pe_load pulses, one pe_rst pulse; result=32; result_valid stays high until ready.
- k_len=0 -> result_valid within 2 cycles of start, result=0, no pe_load, no pe_rst.
- k_len=2, all operands 0xFFFFFFFF -> result=0x1_FFFFFFFC_00000002 (65-bit).
- result_ready held low 5 cycles with a start pulse during OUT -> result stable, start ignored, busy=1; ready=1 -> IDLE the next cycle.
- k_len=20 -> saturated to 16: 16 pe_load pulses, addresses 0..15, no wrap.
- rst asserted in WAIT -> next cycle IDLE with all reset values; with the optional feature enabled and a PE that never returns pe_done, err=1 after exactly 64 WAIT cycles.
